// File: rtl/uart_tx_word_serializer.sv
// Word-to-byte serializer in front of the UART TX core: a word FIFO that feeds a byte shifter.
// Optional per-word header byte is compiled in with UART_TX_SER_HDR_EN.
module uart_tx_word_serializer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              msb_first,
  input  logic                              next_uart,
  input  logic                              flush,
  output logic [7:0]                        out_byte,
  output logic                              out_valid,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              overflow
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef UART_TX_SER_HDR_EN
  typedef enum logic [1:0] {IDLE, SEND, HDR} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
  logic [7:0] unused_hdr;
  assign unused_hdr = HDR_BYTE;
`endif

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count, count_nxt;
  logic [DATA_W-1:0] sreg, shifted, head;
  logic [IW-1:0]     idx;
  logic              msb_q;
  logic              push, pop, last_byte;

  function automatic logic [7:0] sel_byte(input logic [DATA_W-1:0] w, input logic msb);
    return msb ? w[DATA_W-1 -: 8] : w[7:0];
  endfunction

  // Full blocks writes even when a pop happens the same cycle (no write-through).
  assign in_ready  = (count != LW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready && !flush;
  assign last_byte = (state == SEND) && out_valid && next_uart && (idx == IW'(NBYTES - 1));
  assign pop       = !flush && (count != '0) && ((state == IDLE) || last_byte);
  assign head      = mem[rd_ptr];
  assign shifted   = msb_q ? (sreg << 8) : (sreg >> 8);
  assign level     = count;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + LW'(1);
    else if (pop && !push)
      count_nxt = count - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Byte sequencer; a pop (from IDLE or after the last byte) always reloads the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      idx       <= '0;
      msb_q     <= 1'b0;
      out_byte  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (in_valid && !in_ready)
        overflow <= 1'b1;
      if (pop) begin
        sreg      <= head;
        msb_q     <= msb_first;
        idx       <= '0;
        out_valid <= 1'b1;
        busy      <= 1'b1;
`ifdef UART_TX_SER_HDR_EN
        state     <= HDR;
        out_byte  <= HDR_BYTE;
`else
        state     <= SEND;
        out_byte  <= sel_byte(head, msb_first);
`endif
      end else begin
        case (state)
          IDLE: begin
            out_valid <= 1'b0;
            busy      <= (count_nxt != '0);
          end
          SEND: begin
            if (next_uart) begin
              if (idx != IW'(NBYTES - 1)) begin
                sreg     <= shifted;
                idx      <= idx + IW'(1);
                out_byte <= sel_byte(shifted, msb_q);
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= (count_nxt != '0);
              end
            end
          end
`ifdef UART_TX_SER_HDR_EN
          HDR: begin
            if (next_uart) begin
              state    <= SEND;
              out_byte <= sel_byte(sreg, msb_q);
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Directed self-checking bench for uart_tx_word_serializer (DATA_W=64, FIFO_DEPTH=4).
module tb_uart_tx_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, msb_first, next_uart, flush;
  logic [63:0] in_data;
  logic [7:0]  out_byte;
  logic        out_valid, busy, overflow;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  uart_tx_word_serializer #(.DATA_W(64), .FIFO_DEPTH(4), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .msb_first(msb_first), .next_uart(next_uart), .flush(flush), .out_byte(out_byte),
    .out_valid(out_valid), .busy(busy), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse();
    next_uart = 1'b1;
    tick();
    next_uart = 1'b0;
  endtask

  logic [63:0] w;
  logic [7:0]  exp_b;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; msb_first = 1'b0;
    next_uart = 1'b0; flush = 1'b0;
    #12;
    chk("rst_out_byte", 64'(out_byte), 64'h00);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();

    // LSB-first word
    push_word(64'h0807060504030201);
    chk("lsb_level_after_push", 64'(level), 64'd1);
    chk("lsb_valid_before_pop", 64'(out_valid), 64'd0);
    chk("lsb_busy_after_push", 64'(busy), 64'd1);
    tick();
    chk("lsb_level_after_pop", 64'(level), 64'd0);
`ifdef UART_TX_SER_HDR_EN
    chk("lsb_hdr", 64'(out_byte), 64'hA5);
    pulse();
`endif
    for (int i = 0; i < 8; i++) begin
      chk("lsb_valid", 64'(out_valid), 64'd1);
      chk("lsb_byte", 64'(out_byte), 64'(i + 1));
      pulse();
    end
    chk("lsb_end_valid", 64'(out_valid), 64'd0);
    chk("lsb_end_busy", 64'(busy), 64'd0);

    // MSB-first word; msb_first toggled mid-word must not matter
    msb_first = 1'b1;
    push_word(64'h0807060504030201);
    tick();
`ifdef UART_TX_SER_HDR_EN
    chk("msb_hdr", 64'(out_byte), 64'hA5);
    pulse();
`endif
    for (int i = 0; i < 8; i++) begin
      if (i == 2) msb_first = 1'b0;
      chk("msb_byte", 64'(out_byte), 64'(8 - i));
      pulse();
    end
    chk("msb_end_valid", 64'(out_valid), 64'd0);

    // Fill FIFO: 5 pushes, first is popped, then one overflowing push
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(k * 16 + j);
      in_data = w;
      tick();
    end
    in_valid = 1'b0;
    chk("full_level", 64'(level), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_no_ovf_yet", 64'(overflow), 64'd0);
    push_word({8{8'hEE}});
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd4);
    // Drain continuously with next_uart held high
    next_uart = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef UART_TX_SER_HDR_EN
      chk("drain_hdr", 64'(out_byte), 64'hA5);
      tick();
`endif
      for (int j = 0; j < 8; j++) begin
        exp_b = 8'(k * 16 + j);
        chk("drain_valid", 64'(out_valid), 64'd1);
        chk("drain_byte", 64'(out_byte), 64'(exp_b));
        tick();
      end
    end
    next_uart = 1'b0;
    chk("drain_end_valid", 64'(out_valid), 64'd0);
    chk("drain_end_busy", 64'(busy), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Flush after 3 bytes with 2 words queued
    in_valid = 1'b1;
    in_data = 64'h0807060504030201; tick();
    in_data = 64'h2827262524232221; tick();
    in_data = 64'h3837363534333231; tick();
    in_valid = 1'b0;
    chk("pre_flush_level", 64'(level), 64'd2);
`ifdef UART_TX_SER_HDR_EN
    pulse();
`endif
    pulse(); pulse(); pulse();
    chk("pre_flush_byte", 64'(out_byte), 64'h04);
    flush = 1'b1; next_uart = 1'b1;
    tick();
    flush = 1'b0; next_uart = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_overflow", 64'(overflow), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    tick();
    chk("flush_stays_idle", 64'(out_valid), 64'd0);
    push_word(64'h1817161514131211);
    tick();
`ifdef UART_TX_SER_HDR_EN
    pulse();
`endif
    for (int i = 0; i < 8; i++) begin
      chk("post_flush_byte", 64'(out_byte), 64'(8'h11 + 8'(i)));
      pulse();
    end
    chk("post_flush_end", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-word
    push_word(64'h0807060504030201);
    push_word(64'h2827262524232221);
    pulse(); pulse();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_byte", 64'(out_byte), 64'h00);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk("post_rst_quiet", 64'(out_valid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
    end

`ifdef UART_TX_SER_HDR_EN
    begin
      logic [7:0] hdr_exp [9];
      hdr_exp = '{8'hA5, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      msb_first = 1'b0;
      push_word(64'h1122334455667788);
      tick();
      for (int i = 0; i < 9; i++) begin
        chk("hdr_seq", 64'(out_byte), 64'(hdr_exp[i]));
        pulse();
      end
      chk("hdr_end", 64'(out_valid), 64'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_serializer.md
# uart_tx_word_serializer

Parametrised word-to-byte serializer feeding the UART transmitter. Buffers up to FIFO_DEPTH words of DATA_W bits, then presents each word one byte at a time to the UART, advancing on the UART's per-byte completion pulse. Byte order is selectable per word. Includes a flush, a sticky overflow flag and an optional per-word header byte. Sits between the compute/result path and the UART TX core.

## Interface
- DATA_W, 64, word width; multiple of 8, 8..256; NBYTES = DATA_W/8
- FIFO_DEPTH, 4, word FIFO depth; power of 2, 2..16
- HDR_BYTE, 8'hA5, header value; used only with UART_TX_SER_HDR_EN
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  word offered on in_data
- in_ready  out  1  FIFO not full; equals !full, combinational from count
- in_data  in  DATA_W  word to send
- msb_first  in  1  byte order, sampled at word pop: 1 = byte NBYTES-1 first, 0 = byte 0 first
- next_uart  in  1  single-cycle pulse from UART: current byte consumed
- flush  in  1  synchronous abort; clears FIFO and current word
- out_byte  out  8  byte presented to UART, registered
- out_valid  out  1  out_byte valid, registered
- busy  out  1  state != IDLE or FIFO non-empty
- level  out  $clog2(FIFO_DEPTH+1)  words in FIFO, excluding the word being sent
- overflow  out  1  sticky: in_valid seen while in_ready=0

## Operation
- Write: on a clk edge with in_valid & in_ready & !flush, in_data is pushed into the FIFO.
- FSM states: IDLE, HDR (macro only), SEND.
- IDLE:
  - out_valid=0.
  - If the FIFO is non-empty and flush=0: pop the head word into the shift register, latch msb_first, set idx=0.
  - Go to HDR if the macro is defined, else go to SEND and present the first byte with out_valid=1.
- HDR:
  - out_byte=HDR_BYTE, out_valid=1.
  - On next_uart: present the first data byte and go to SEND.
- SEND:
  - out_byte is the low byte of the shift register (LSB order) or the high byte (MSB order).
  - On next_uart with idx<NBYTES-1: shift by 8, idx+1, present the next byte.
  - On next_uart with idx=NBYTES-1 and FIFO non-empty: pop the next word with no idle cycle, going to HDR or SEND as in IDLE.
  - On next_uart with idx=NBYTES-1 and FIFO empty: go to IDLE with out_valid=0.
- next_uart is ignored when out_valid=0.
- A word pushed while in SEND is never reordered ahead of earlier words.
- Push and pop in the same cycle: level is unchanged. When full, in_ready=0 even if a pop occurs that cycle; there is no write-through.
- Overflow: in_valid & !in_ready sets overflow=1. It is cleared only by flush or rst. The offered word is dropped.
- Flush has priority over everything. Next cycle: FIFO empty, level=0, state IDLE, out_valid=0, overflow=0. in_data is not written that cycle, and next_uart is ignored that cycle.
- Reset (any time, including mid-word): state IDLE, FIFO empty. out_byte=8'h00, out_valid=0, busy=0, level=0, overflow=0, in_ready=1. The partially sent word is discarded.

## Timing
- Word accepted at edge N: level updates after N. Pop occurs at edge N+1 if IDLE, giving out_valid=1 and the first byte after N+1.
- Byte advance: next_uart high at edge M → new out_byte after M.
- Back-to-back words: the last byte of word k is followed directly by the first byte (or header) of word k+1 after the same edge.
- Without header, a word takes exactly NBYTES next_uart pulses. With header, it takes NBYTES+1.
- in_ready is combinational from level. All other outputs are registered.

## Configuration
- UART_TX_SER_HDR_EN defined:
  - HDR state is compiled in.
  - Every word is preceded by HDR_BYTE.
  - The header is not affected by msb_first.
- UART_TX_SER_HDR_EN undefined:
  - No HDR state.
  - The first data byte is presented directly at pop.
  - The HDR_BYTE parameter is unused.

## Test plan
- DATA_W=64, msb_first=0:
  - Stimulus: push 64'h0807060504030201, then 8 next_uart pulses.
  - Response: bytes 01..08 in order, then out_valid=0, busy=0.
- Same word, msb_first=1:
  - Response: bytes 08..01.
  - Toggling msb_first mid-word does not change the order of the word in flight.
- FIFO_DEPTH=4:
  - Stimulus: push 5 words with no next_uart. The first is popped.
  - Response: level=4, in_ready=0. A 6th push sets overflow=1 and its data is never sent.
  - Drain: byte stream is continuous across word boundaries, with no cycle where out_valid=0.
- Flush asserted after 3 of 8 bytes with 2 words queued:
  - Response next cycle: out_valid=0, level=0, overflow=0.
  - A subsequent push is sent from its byte 0.
- rst pulsed mid-word:
  - Response: all outputs at reset values immediately (asynchronous).
  - After release, next_uart pulses produce nothing until a new push.
- With UART_TX_SER_HDR_EN:
  - Stimulus: push 64'h1122334455667788, msb_first=0, then 9 pulses.
  - Response: A5, 88, 77, 66, 55, 44, 33, 22, 11.
